// File: rtl/send_queue_writer_pkg.sv
// Shared types for the UART transmit ring (writer and output_manager).
// Pointer width and depth are fixed here so both sides agree.
package send_queue_pkg;

    localparam int SQ_DEPTH = 512;
    localparam int SQ_PTR_W = 9;

    typedef logic [SQ_PTR_W-1:0] sq_ptr_t;

    typedef enum logic {
        IDLE = 1'b0,
        WORD = 1'b1
    } sq_state_t;

endpackage

// File: rtl/send_queue_writer.sv
// Producer side of the UART transmit ring: byte/word requests into send_queue.
// Word requests are serialized MSB-first only when SEND_QUEUE_WORD_EN is defined.
module send_queue_writer
    import send_queue_pkg::*;
#(
    parameter int DEPTH = SQ_DEPTH,
    parameter int PTR_W = SQ_PTR_W
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             in_valid,
    input  logic             in_word,
    input  logic [31:0]      in_data,
    output logic             in_ready,
    output logic [7:0]       send_queue [DEPTH],
    output logic [PTR_W-1:0] queue_t,
    input  logic [PTR_W-1:0] queue_s,
    output logic             full,
    output logic [PTR_W-1:0] level
);

    logic       wr_en;
    logic [7:0] wr_data;

    assign full  = (PTR_W'(queue_t + 1'b1) == queue_s);
    assign level = PTR_W'(queue_t - queue_s);

`ifdef SEND_QUEUE_WORD_EN

    sq_state_t   state;
    logic [1:0]  idx;
    logic [23:0] latch;

    assign in_ready = (state == IDLE) && !full;

    always_comb begin
        wr_en   = 1'b0;
        wr_data = in_data[7:0];
        if (state == WORD) begin
            wr_en = !full;
            case (idx)
                2'd1:    wr_data = latch[23:16];
                2'd2:    wr_data = latch[15:8];
                default: wr_data = latch[7:0];
            endcase
        end else begin
            wr_en   = in_valid && in_ready;
            wr_data = in_word ? in_data[31:24] : in_data[7:0];
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state <= IDLE;
            idx   <= 2'd0;
            latch <= 24'd0;
        end else if (state == IDLE) begin
            if (in_valid && in_ready && in_word) begin
                state <= WORD;
                idx   <= 2'd1;
                latch <= in_data[23:0];
            end
        end else if (!full) begin
            if (idx == 2'd3) begin
                state <= IDLE;
                idx   <= 2'd0;
            end else begin
                idx <= idx + 2'd1;
            end
        end
    end

`else

    logic unused_word;

    assign unused_word = ^{in_word, in_data[31:8]};
    assign in_ready    = !full;

    always_comb begin
        wr_en   = in_valid && in_ready;
        wr_data = in_data[7:0];
    end

`endif

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            queue_t <= '0;
        end else if (wr_en) begin
            queue_t <= PTR_W'(queue_t + 1'b1);
        end
    end

    // Storage is deliberately not reset; only the pointers define content.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            send_queue[queue_t] <= wr_data;
        end
    end

endmodule

// File: tb/tb_send_queue_writer.sv
// Directed bench for send_queue_writer; word tests run when SEND_QUEUE_WORD_EN is defined.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_send_queue_writer;

    logic        CLK;
    logic        RSTN;
    logic        in_valid;
    logic        in_word;
    logic [31:0] in_data;
    logic        in_ready;
    logic [7:0]  sq [512];
    logic [8:0]  queue_t;
    logic [8:0]  queue_s;
    logic        full;
    logic [8:0]  level;

    int n_run;
    int n_fail;

    send_queue_writer dut (
        .CLK        (CLK),
        .RSTN       (RSTN),
        .in_valid   (in_valid),
        .in_word    (in_word),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .send_queue (sq),
        .queue_t    (queue_t),
        .queue_s    (queue_s),
        .full       (full),
        .level      (level)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RSTN     = 1'b0;
        in_valid = 1'b0;
        in_word  = 1'b0;
        in_data  = 32'd0;
        queue_s  = 9'd0;
        step();
        RSTN = 1'b1;
        #1;
    endtask

    task automatic put_byte(input logic [7:0] d);
        in_valid = 1'b1;
        in_word  = 1'b0;
        in_data  = {24'hFFFFFF, d};
        step();
        in_valid = 1'b0;
    endtask

    task automatic fill(input int n);
        for (int i = 0; i < n; i++) put_byte(8'(i));
    endtask

    task automatic test_reset();
        do_reset();
        n_run++;
        if (queue_t !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_qt got %0d exp 0", queue_t);
        end
        n_run++;
        if (level !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_level got %0d exp 0", level);
        end
        n_run++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready got %b exp 1", in_ready);
        end
        n_run++;
        if (full !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_full got %b exp 0", full);
        end
    endtask

    task automatic test_byte();
        do_reset();
        put_byte(8'h41);
        n_run++;
        if (sq[0] !== 8'h41) begin
            n_fail++;
            $display("FAIL byte_data got %h exp 41", sq[0]);
        end
        n_run++;
        if (queue_t !== 9'd1) begin
            n_fail++;
            $display("FAIL byte_qt got %0d exp 1", queue_t);
        end
        n_run++;
        if (level !== 9'd1) begin
            n_fail++;
            $display("FAIL byte_level got %0d exp 1", level);
        end
        in_data = 32'h0000_0099;
        step();
        step();
        n_run++;
        if (queue_t !== 9'd1) begin
            n_fail++;
            $display("FAIL idle_qt got %0d exp 1", queue_t);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        in_valid = 1'b1;
        in_word  = 1'b0;
        in_data  = 32'h10;
        step();
        in_data  = 32'h20;
        step();
        in_data  = 32'h30;
        step();
        in_valid = 1'b0;
        n_run++;
        if ({sq[0], sq[1], sq[2]} !== 24'h102030) begin
            n_fail++;
            $display("FAIL b2b_data got %h exp 102030",
                     {sq[0], sq[1], sq[2]});
        end
        n_run++;
        if (queue_t !== 9'd3 || level !== 9'd3) begin
            n_fail++;
            $display("FAIL b2b_ptr got qt=%0d lvl=%0d exp 3/3",
                     queue_t, level);
        end
    endtask

    task automatic test_full();
        do_reset();
        fill(511);
        n_run++;
        if (full !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_flags got full=%b rdy=%b exp 1/0",
                     full, in_ready);
        end
        n_run++;
        if (queue_t !== 9'd511 || level !== 9'd511) begin
            n_fail++;
            $display("FAIL full_ptr got qt=%0d lvl=%0d exp 511/511",
                     queue_t, level);
        end
        in_valid = 1'b1;
        in_data  = 32'h0000_00AA;
        step();
        n_run++;
        if (queue_t !== 9'd511 || sq[511] === 8'hAA) begin
            n_fail++;
            $display("FAIL full_block got qt=%0d s511=%h exp 511/not-aa",
                     queue_t, sq[511]);
        end
        queue_s = 9'd1;
        #1;
        step();
        in_valid = 1'b0;
        n_run++;
        if (queue_t !== 9'd0 || sq[511] !== 8'hAA) begin
            n_fail++;
            $display("FAIL full_resume got qt=%0d s511=%h exp 0/aa",
                     queue_t, sq[511]);
        end
        n_run++;
        if (level !== 9'd511) begin
            n_fail++;
            $display("FAIL full_level got %0d exp 511", level);
        end
    endtask

`ifdef SEND_QUEUE_WORD_EN

    task automatic test_word_order();
        int lows;
        do_reset();
        fill(5);
        in_valid = 1'b1;
        in_word  = 1'b1;
        in_data  = 32'hDEADBEEF;
        lows     = 0;
        step();
        in_valid = 1'b0;
        in_word  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (in_ready !== 1'b1) lows++;
            step();
        end
        n_run++;
        if (lows != 3) begin
            n_fail++;
            $display("FAIL word_ready_low got %0d exp 3", lows);
        end
        n_run++;
        if ({sq[5], sq[6], sq[7], sq[8]} !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL word_order got %h exp deadbeef",
                     {sq[5], sq[6], sq[7], sq[8]});
        end
        n_run++;
        if (queue_t !== 9'd9) begin
            n_fail++;
            $display("FAIL word_qt got %0d exp 9", queue_t);
        end
    endtask

    task automatic test_wrap_word();
        do_reset();
        fill(510);
        queue_s  = 9'd100;
        in_valid = 1'b1;
        in_word  = 1'b1;
        in_data  = 32'h01020304;
        step();
        in_valid = 1'b0;
        in_word  = 1'b0;
        step();
        step();
        step();
        n_run++;
        if ({sq[510], sq[511], sq[0], sq[1]} !== 32'h01020304) begin
            n_fail++;
            $display("FAIL wrap_data got %h exp 01020304",
                     {sq[510], sq[511], sq[0], sq[1]});
        end
        n_run++;
        if (queue_t !== 9'd2 || level !== 9'd414) begin
            n_fail++;
            $display("FAIL wrap_ptr got qt=%0d lvl=%0d exp 2/414",
                     queue_t, level);
        end
    endtask

    task automatic test_reset_mid_word();
        do_reset();
        for (int i = 0; i < 4; i++) put_byte(8'h55);
        do_reset();
        in_valid = 1'b1;
        in_word  = 1'b1;
        in_data  = 32'hA1B2C3D4;
        step();
        in_valid = 1'b0;
        in_word  = 1'b0;
        step();
        RSTN = 1'b0;
        #1;
        n_run++;
        if (queue_t !== 9'd0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_state got qt=%0d rdy=%b exp 0/1",
                     queue_t, in_ready);
        end
        step();
        RSTN = 1'b1;
        step();
        step();
        step();
        n_run++;
        if (queue_t !== 9'd0) begin
            n_fail++;
            $display("FAIL rstmid_qt got %0d exp 0", queue_t);
        end
        n_run++;
        if ({sq[0], sq[1], sq[2], sq[3]} !== 32'hA1B25555) begin
            n_fail++;
            $display("FAIL rstmid_data got %h exp a1b25555",
                     {sq[0], sq[1], sq[2], sq[3]});
        end
    endtask

`else

    task automatic test_macro_off();
        do_reset();
        put_byte(8'h00);
        in_valid = 1'b1;
        in_word  = 1'b1;
        in_data  = 32'h11223344;
        step();
        in_valid = 1'b0;
        in_word  = 1'b0;
        n_run++;
        if (sq[1] !== 8'h44) begin
            n_fail++;
            $display("FAIL off_data got %h exp 44", sq[1]);
        end
        n_run++;
        if (queue_t !== 9'd2 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL off_ptr got qt=%0d rdy=%b exp 2/1",
                     queue_t, in_ready);
        end
        step();
        n_run++;
        if (queue_t !== 9'd2) begin
            n_fail++;
            $display("FAIL off_no_extra got %0d exp 2", queue_t);
        end
    endtask

`endif

    initial begin
        n_run    = 0;
        n_fail   = 0;
        RSTN     = 1'b0;
        in_valid = 1'b0;
        in_word  = 1'b0;
        in_data  = 32'd0;
        queue_s  = 9'd0;
        #2;
        test_reset();
        test_byte();
        test_back_to_back();
        test_full();
`ifdef SEND_QUEUE_WORD_EN
        test_word_order();
        test_wrap_word();
        test_reset_mid_word();
`else
        test_macro_off();
`endif
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/send_queue_writer.md
# send_queue_writer

Producer side of the UART transmit path. Accepts byte or 32-bit word output requests from the CPU core, serializes them into bytes, and writes them into the 512-entry transmit ring buffer. It owns the ring storage and the tail pointer `queue_t`. `output_manager` consumes the ring by reading `send_queue[queue_s]` and advancing `queue_s`. When the ring is full, the CPU is back-pressured through a valid/ready handshake.

## Interface
- `DEPTH`, 512, ring entries; must be a power of two.
- `PTR_W`, 9, pointer width, equal to log2(`DEPTH`).
- `CLK` in 1: system clock; all logic on the rising edge.
- `RSTN` in 1: asynchronous, active-low reset.
- `in_valid` in 1: CPU output request.
- `in_word` in 1: 1 = 4-byte word request, 0 = single byte (`in_data[7:0]`).
- `in_data` in 32: payload.
- `in_ready` out 1: block can accept a request this cycle.
- `send_queue` out 8×`DEPTH`: ring storage, read by `output_manager`.
- `queue_t` out `PTR_W`: tail, the next slot to write.
- `queue_s` in `PTR_W`: head, owned by `output_manager`.
- `full` out 1: `queue_t + 1 == queue_s` (mod `DEPTH`).
- `level` out `PTR_W`: `queue_t - queue_s` (mod `DEPTH`), number of bytes pending.

## Operation
- Ring capacity is `DEPTH-1` = 511 bytes. One slot is sacrificed so that `queue_t == queue_s` always means empty.
- States:
  - IDLE: `in_ready = !full`.
  - WORD: serializing a latched word; `in_ready = 0`.
- Transfer occurs on a rising edge where `in_valid && in_ready`.
- Byte transfer in IDLE:
  - `send_queue[queue_t] <= in_data[7:0]`, `queue_t <= queue_t+1`.
  - State stays IDLE.
- Word transfer in IDLE:
  - Write byte `in_data[31:24]` and advance `queue_t`.
  - Latch `in_data[23:0]`, set byte index to 1, go to WORD.
- WORD:
  - Each cycle with `!full`, write the next byte MSB-first (`[23:16]`, `[15:8]`, `[7:0]`) and advance `queue_t`.
  - If `full`, hold and write nothing.
  - After the byte at index 3 is written, return to IDLE.
- Pointer arithmetic is `PTR_W`-bit unsigned; wrap from 511 to 0 is natural overflow.
- `queue_s` is treated as asynchronous-to-intent: it may advance in any cycle. `full` and `level` are combinational from the current `queue_t` and `queue_s`.
- Simultaneous write and head advance in a full ring: the write is blocked this cycle because `full` is evaluated before `queue_s` updates. It proceeds the next cycle.
- Storage contents are not reset. Only pointers and state are reset.

## Timing
- Reset values:
  - `queue_t` = 0, state IDLE, byte index 0, latched word 0.
  - `in_ready` = 1, since `full` = 0 when `queue_s` = 0.
  - `level` = 0.
- Byte latency:
  - Data is visible at `send_queue[old queue_t]` and `queue_t` is incremented one edge after transfer.
  - `output_manager` may read it from the following cycle.
- Word with no back-pressure: 4 consecutive edges (transfer edge plus 3 WORD edges). `in_ready` is low for 3 cycles and re-asserts in the cycle after the last byte is written.
- Max sustained throughput: 1 byte/cycle.
- Reset asserted mid-word discards the remaining bytes. Bytes already written stay, but `queue_t` returns to 0. `RSTN` must therefore also reset `queue_s` in `output_manager` (shared reset net) so that pointers stay consistent.
- `in_valid` may drop without a transfer; no state change results.

## Configuration
- `SEND_QUEUE_WORD_EN` defined: word requests are supported as above.
- `SEND_QUEUE_WORD_EN` undefined:
  - The WORD state and the 24-bit latch are removed.
  - `in_word` is ignored; every transfer is a byte write of `in_data[7:0]`.
  - `in_ready = !full` always.

## Structure
- Package `send_queue_pkg` holds:
  - Constants `SQ_DEPTH` = 512 and `SQ_PTR_W` = 9.
  - Typedef `sq_ptr_t`, i.e. `logic [SQ_PTR_W-1:0]`.
  - Enum `sq_state_t` {IDLE, WORD}.
- Both this block and `output_manager` import the package.
- No sub-module. The serializer is the state machine inline. The storage is inferred distributed/block RAM with one write port, exposed as the array output.

## Test plan
- Byte after reset: `in_valid=1`, `in_word=0`, `in_data=0x41` → `send_queue[0]=0x41`, `queue_t=1`, `level=1` one edge later.
- Word ordering: word `0xDEADBEEF` at `queue_t=5` → slots 5..8 = `DE AD BE EF`, `queue_t=9`, `in_ready` low for exactly 3 cycles.
- Full stall: `queue_s` held at 0, 511 byte writes → `full=1`, `in_ready=0`, the 512th request does not transfer. `queue_s` steps to 1 → write occurs next edge and `queue_t` wraps to 0.
- Wrap mid-word: `queue_t=510`, `queue_s=100`, word `0x01020304` → slots 510, 511, 0, 1 = `01 02 03 04`, `queue_t=2`.
- Reset mid-word: `RSTN` low after the 2nd byte → `queue_t=0`, state IDLE, `in_ready=1`, and no further bytes written after release.
- Macro off: `in_word=1`, `in_data=0x11223344` → single byte `0x44` written, `queue_t+1`.
